// File: rtl/div_recoded_float32_iter.sv
// Iterative recoded-float32 divider: radix-2 restoring quotient loop with
// valid/ready handshakes, IEEE rounding modes and exception flags.
module div_recoded_float32_iter (
   input  logic        clock,
   input  logic        reset,
   input  logic        inValid,
   output logic        inReady,
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic [1:0]  roundingMode,
   output logic        outValid,
   input  logic        outReady,
   output logic [32:0] out,
   output logic [4:0]  exceptionFlags
);

   typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

   localparam logic [32:0] NAN_MAG = {1'b0, 9'h1C0, 23'h7FFFFF};
   localparam logic [32:0] INF_MAG = {1'b0, 9'h180, 23'h000000};
   localparam logic [32:0] MAX_MAG = {1'b0, 9'h17F, 23'h7FFFFF};

   state_t             state_reg, state_next;
   logic [4:0]         count_reg, count_next;
   logic [25:0]        rem_reg, rem_next;
   logic [25:0]        q_reg, q_next;
   logic [23:0]        sig_b_reg, sig_b_next;
   logic signed [10:0] sexp_reg, sexp_next;
   logic               sign_reg, sign_next;
   logic [1:0]         rm_reg, rm_next;
   logic [32:0]        out_reg, out_next;
   logic [4:0]         flags_reg, flags_next;

   // ---------------- operand classification ----------------
   logic [8:0]  exp_a, exp_b;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
   logic        sign_ab;
   logic [32:0] spec_out;
   logic [4:0]  spec_flags;

   assign exp_a   = a[31:23];
   assign exp_b   = b[31:23];
   assign a_nan   = (exp_a[8:6] == 3'b111);
   assign b_nan   = (exp_b[8:6] == 3'b111);
   assign a_inf   = (exp_a[8:6] == 3'b110);
   assign b_inf   = (exp_b[8:6] == 3'b110);
   assign a_zero  = (exp_a[8:6] == 3'b000);
   assign b_zero  = (exp_b[8:6] == 3'b000);
   assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign sign_ab = a[32] ^ b[32];

   always_comb begin
      spec_out   = {sign_ab, 32'd0};
      spec_flags = 5'b00000;
      if (a_nan || b_nan) begin
         spec_out      = NAN_MAG | {sign_ab, 32'd0};
         spec_flags[4] = (a_nan & ~a[22]) | (b_nan & ~b[22]);
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_out   = NAN_MAG | {sign_ab, 32'd0};
         spec_flags = 5'b10000;
      end else if (a_inf) begin
         spec_out = INF_MAG | {sign_ab, 32'd0};
      end else if (b_zero) begin
         spec_out   = INF_MAG | {sign_ab, 32'd0};
         spec_flags = 5'b01000;
      end
   end

   // ---------------- common-case setup ----------------
   logic [23:0]        sig_a, sig_b;
   logic               a_lt;
   logic [25:0]        rem_setup;
   logic signed [10:0] sexp_setup;

   assign sig_a      = {1'b1, a[22:0]};
   assign sig_b      = {1'b1, b[22:0]};
   assign a_lt       = (sig_a < sig_b);
   assign rem_setup  = a_lt ? {1'b0, sig_a, 1'b0} : {2'b00, sig_a};
   assign sexp_setup = {2'b00, exp_a} - {2'b00, exp_b} + 11'h100 - {10'd0, a_lt};

   // ---------------- quotient step ----------------
   logic [26:0] diff;
   logic [26:0] diff_sel;

   assign diff     = {1'b0, rem_reg} - {3'b000, sig_b_reg};
   assign diff_sel = diff[26] ? {1'b0, rem_reg} : diff;

   // ---------------- rounding ----------------
   logic signed [10:0] k_wide, exp_r;
   logic               tiny, round_bit, sticky, lsb, inexact, inc, carry, to_inf;
   logic [4:0]         k;
   logic [25:0]        qs, lost_vec;
   logic [24:0]        rounded;
   logic [49:0]        rsh;
   logic [32:0]        round_out;
   logic [4:0]         round_flags;

   assign k_wide = 11'sh082 - sexp_reg;
   assign tiny   = (sexp_reg <= 11'sh081);
   assign k      = !tiny ? 5'd0 : ((k_wide > 11'sd25) ? 5'd25 : k_wide[4:0]);
   assign qs     = q_reg >> k;

   // Low quotient bits pushed below the subnormal LSB join the sticky bit.
   genvar gi;
   generate
      for (gi = 0; gi < 26; gi++) begin : g_lost
         assign lost_vec[gi] = q_reg[gi] & (k > 5'(gi));
      end
   endgenerate

   assign round_bit = qs[1];
   assign sticky    = qs[0] | (|lost_vec) | (|rem_reg);
   assign lsb       = qs[2];
   assign inexact   = round_bit | sticky;

   always_comb begin
      case (rm_reg)
         2'b00:   inc = round_bit & (sticky | lsb);
         2'b10:   inc = sign_reg & inexact;
         2'b11:   inc = ~sign_reg & inexact;
         default: inc = 1'b0;
      endcase
   end

   assign rounded = {1'b0, qs[25:2]} + {24'd0, inc};
   assign rsh     = {25'd0, rounded} << k;
   assign carry   = |rsh[49:24];
   // With the full cap every bit is a rounding bit; an increment lands on the smallest subnormal.
   assign exp_r   = ((k == 5'd25) && (rounded != 25'd0)) ? 11'sh06B
                                                         : sexp_reg + {10'd0, carry};
   assign to_inf  = (rm_reg == 2'b00) | ((rm_reg == 2'b10) & sign_reg) |
                    ((rm_reg == 2'b11) & ~sign_reg);

   always_comb begin
      round_out   = {sign_reg, exp_r[8:0], rsh[22:0]};
      round_flags = {3'b000, tiny & inexact, inexact};
      if (exp_r < 11'sh06B) begin
         round_out   = {sign_reg, 32'd0};
         round_flags = 5'b00011;
      end else if (exp_r >= 11'sh180) begin
         round_out   = (to_inf ? INF_MAG : MAX_MAG) | {sign_reg, 32'd0};
         round_flags = 5'b00101;
      end
   end

   // ---------------- control ----------------
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      rem_next   = rem_reg;
      q_next     = q_reg;
      sig_b_next = sig_b_reg;
      sexp_next  = sexp_reg;
      sign_next  = sign_reg;
      rm_next    = rm_reg;
      out_next   = out_reg;
      flags_next = flags_reg;
      case (state_reg)
         IDLE: begin
            if (inValid) begin
               sign_next = sign_ab;
               rm_next   = roundingMode;
               if (special) begin
                  out_next   = spec_out;
                  flags_next = spec_flags;
                  state_next = DONE;
               end else begin
                  sig_b_next = sig_b;
                  rem_next   = rem_setup;
                  sexp_next  = sexp_setup;
                  q_next     = 26'd0;
                  count_next = 5'd25;
                  state_next = ITER;
               end
            end
         end
         ITER: begin
            q_next   = {q_reg[24:0], ~diff[26]};
            rem_next = 26'({diff_sel, 1'b0});
            if (count_reg == 5'd0) begin
               state_next = ROUND;
            end else begin
               count_next = count_reg - 5'd1;
            end
         end
         ROUND: begin
            out_next   = round_out;
            flags_next = round_flags;
            state_next = DONE;
         end
         DONE: begin
            if (outReady) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= 5'd0;
         rem_reg   <= 26'd0;
         q_reg     <= 26'd0;
         sig_b_reg <= 24'd0;
         sexp_reg  <= 11'sd0;
         sign_reg  <= 1'b0;
         rm_reg    <= 2'b00;
         out_reg   <= 33'd0;
         flags_reg <= 5'd0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         rem_reg   <= rem_next;
         q_reg     <= q_next;
         sig_b_reg <= sig_b_next;
         sexp_reg  <= sexp_next;
         sign_reg  <= sign_next;
         rm_reg    <= rm_next;
         out_reg   <= out_next;
         flags_reg <= flags_next;
      end
   end

   assign inReady        = (state_reg == IDLE);
   assign outValid       = (state_reg == DONE);
   assign out            = out_reg;
   assign exceptionFlags = flags_reg;

endmodule
